scr1_mem_arb2: RTL and testbench

- Two-requester arbiter that shares one core memory interface (req/ack/resp handshake) between the instruction-fetch port and the data port.
- Typical downstream: a single scr1_dmem_ahb-style bridge or a single-port TCM.
- Selects one request per cycle (round-robin or dmem-fixed priority) and holds the selection stable until it is accepted.
- Records the owner of every accepted request in an in-order ID FIFO and steers each downstream response back to its owner.

---
 rtl/scr1_mem_arb2.sv | 200 ++++++++++++++++++++
 tb/tb_scr1_mem_arb2.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_mem_arb2.sv
// Two-requester memory arbiter: shares one req/ack/resp memory port between imem and dmem,
// keeps the selection stable until accepted and steers responses back via an in-order owner FIFO.

package scr1_memif_pkg;
  localparam int unsigned SCR1_AHB_WIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_mem_arb2
  import scr1_memif_pkg::*;
#(
  parameter int unsigned SCR1_ARB_OUTSTANDING = 2,
  parameter bit          SCR1_ARB_DMEM_PRIO   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // imem port
  output logic                      imem_req_ack,
  input  logic                      imem_req,
  input  type_scr1_mem_cmd_e        imem_cmd,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_addr,
  output logic [SCR1_AHB_WIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e       imem_resp,
  // dmem port
  output logic                      dmem_req_ack,
  input  logic                      dmem_req,
  input  type_scr1_mem_cmd_e        dmem_cmd,
  input  type_scr1_mem_width_e      dmem_width,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_wdata,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e       dmem_resp,
  // shared downstream port
  input  logic                      mem_req_ack,
  output logic                      mem_req,
  output type_scr1_mem_cmd_e        mem_cmd,
  output type_scr1_mem_width_e      mem_width,
  output logic [SCR1_AHB_WIDTH-1:0] mem_addr,
  output logic [SCR1_AHB_WIDTH-1:0] mem_wdata,
  input  logic [SCR1_AHB_WIDTH-1:0] mem_rdata,
  input  type_scr1_mem_resp_e       mem_resp
);

  localparam int unsigned DEPTH = SCR1_ARB_OUTSTANDING;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic        ID_IMEM = 1'b0;
  localparam logic        ID_DMEM = 1'b1;

  logic [DEPTH-1:0] id_fifo;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock, lock_nxt;
  logic             lock_id, lock_id_nxt;
  logic             last_grant, last_grant_nxt;

  logic sel;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (cnt == CNT_W'(DEPTH));
  assign fifo_empty = (cnt == '0);
  assign head_id    = id_fifo[rd_ptr];

  // Owner selection: a held (unaccepted) request always keeps the port
  always_comb begin
    sel = ID_IMEM;
    if (lock) begin
      sel = lock_id;
    end else if (dmem_req & ~imem_req) begin
      sel = ID_DMEM;
    end else if (dmem_req & imem_req) begin
      sel = SCR1_ARB_DMEM_PRIO ? ID_DMEM : ~last_grant;
    end
  end

  assign mem_req      = rst_n & (imem_req | dmem_req) & ~fifo_full;
  assign accept       = mem_req & mem_req_ack;
  assign imem_req_ack = accept & (sel == ID_IMEM);
  assign dmem_req_ack = accept & (sel == ID_DMEM);

  always_comb begin
    mem_cmd   = imem_cmd;
    mem_width = SCR1_MEM_WIDTH_WORD;
    mem_addr  = imem_addr;
    mem_wdata = '0;
    if (sel == ID_DMEM) begin
      mem_cmd   = dmem_cmd;
      mem_width = dmem_width;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end
  end

  // A response with nothing outstanding is dropped rather than underflowing
  assign pop = rst_n & (mem_resp != SCR1_MEM_RESP_NOTRDY) & ~fifo_empty;

  always_comb begin
    imem_resp = SCR1_MEM_RESP_NOTRDY;
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    if (pop) begin
      if (head_id == ID_DMEM) begin
        dmem_resp = mem_resp;
      end else begin
        imem_resp = mem_resp;
      end
    end
  end

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  // Next-state for lock, round-robin history and FIFO bookkeeping
  always_comb begin
    lock_nxt       = lock;
    lock_id_nxt    = lock_id;
    last_grant_nxt = last_grant;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    cnt_nxt        = cnt;
    if (accept) begin
      lock_nxt       = 1'b0;
      last_grant_nxt = sel;
      wr_ptr_nxt     = ptr_inc(wr_ptr);
    end else if (mem_req) begin
      lock_nxt    = 1'b1;
      lock_id_nxt = sel;
    end
    if (pop) begin
      rd_ptr_nxt = ptr_inc(rd_ptr);
    end
    case ({accept, pop})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock       <= 1'b0;
      lock_id    <= ID_IMEM;
      last_grant <= ID_IMEM;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
    end else begin
      lock       <= lock_nxt;
      lock_id    <= lock_id_nxt;
      last_grant <= last_grant_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_fifo <= '0;
    end else if (accept) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

`ifdef SCR1_SIM_ENV
  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({imem_req, dmem_req}));
  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(mem_resp));
  assert property (@(posedge clk) disable iff (!rst_n) imem_req |-> (imem_cmd == SCR1_MEM_CMD_RD));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (mem_resp != SCR1_MEM_RESP_NOTRDY) |-> !fifo_empty);
  assert property (@(posedge clk) disable iff (!rst_n)
                   (mem_req & ~mem_req_ack) |=> ($stable(mem_addr) && $stable(mem_cmd) &&
                                                 $stable(mem_width) && $stable(mem_wdata)));
`endif

endmodule

// File: tb/tb_scr1_mem_arb2.sv
// Bench for scr1_mem_arb2 (defaults: 2 outstanding, round-robin): directed scenarios plus
// random traffic compared against a queue-based model of the arbitration rules.

module tb_scr1_mem_arb2;
  import scr1_memif_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = SCR1_AHB_WIDTH;
  localparam int unsigned VW    = 7 + AW + 1 + 2 + AW;
  localparam int unsigned B_IACK = VW - 2;
  localparam int unsigned B_DACK = VW - 3;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 imem_req_ack, dmem_req_ack, mem_req;
  logic                 imem_req = 1'b0, dmem_req = 1'b0, mem_req_ack = 1'b0;
  type_scr1_mem_cmd_e   imem_cmd = SCR1_MEM_CMD_RD, dmem_cmd = SCR1_MEM_CMD_RD, mem_cmd;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD, mem_width;
  type_scr1_mem_resp_e  imem_resp, dmem_resp, mem_resp = SCR1_MEM_RESP_NOTRDY;
  logic [AW-1:0]        imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
  logic [AW-1:0]        imem_rdata, dmem_rdata, mem_addr, mem_wdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: owners of accepted-but-unanswered requests, oldest first (0=imem, 1=dmem)
  bit owner_q[$];
  bit last_grant;
  bit held_v;
  bit held_id;

  always #5 clk = ~clk;

  scr1_mem_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_ack(imem_req_ack), .imem_req(imem_req), .imem_cmd(imem_cmd),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req_ack(dmem_req_ack), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_req_ack(mem_req_ack), .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  function automatic void model_reset();
    owner_q.delete();
    last_grant = 1'b0;
    held_v     = 1'b0;
    held_id    = 1'b0;
  endfunction

  function automatic bit model_sel();
    if (held_v) return held_id;
    if (imem_req && !dmem_req) return 1'b0;
    if (dmem_req && !imem_req) return 1'b1;
    return !last_grant;
  endfunction

  function automatic logic [VW-1:0] model_expect();
    logic mreq, iack, dack, c;
    logic [1:0] ir, dr, w;
    logic [AW-1:0] a, wd;
    bit s;
    mreq = 1'b0; iack = 1'b0; dack = 1'b0; c = 1'b0; w = 2'b00; a = '0; wd = '0;
    ir = SCR1_MEM_RESP_NOTRDY;
    dr = SCR1_MEM_RESP_NOTRDY;
    if (rst_n) begin
      s    = model_sel();
      mreq = (imem_req || dmem_req) && (owner_q.size() < DEPTH);
      if (mreq) begin
        a    = s ? dmem_addr : imem_addr;
        c    = s ? dmem_cmd : imem_cmd;
        w    = s ? dmem_width : SCR1_MEM_WIDTH_WORD;
        wd   = s ? dmem_wdata : '0;
        iack = !s && mem_req_ack;
        dack = s && mem_req_ack;
      end
      if (mem_resp != SCR1_MEM_RESP_NOTRDY && owner_q.size() > 0) begin
        if (owner_q[0]) dr = mem_resp;
        else            ir = mem_resp;
      end
    end
    return {mreq, iack, dack, ir, dr, a, c, w, wd};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    logic [AW-1:0] a, wd;
    logic c;
    logic [1:0] w;
    a = '0; wd = '0; c = 1'b0; w = 2'b00;
    if (mem_req) begin
      a = mem_addr; wd = mem_wdata; c = mem_cmd; w = mem_width;
    end
    return {mem_req, imem_req_ack, dmem_req_ack, 2'(imem_resp), 2'(dmem_resp), a, c, w, wd};
  endfunction

  function automatic void model_commit();
    bit s, mreq, acc, popv;
    s    = model_sel();
    mreq = (imem_req || dmem_req) && (owner_q.size() < DEPTH);
    acc  = mreq && mem_req_ack;
    popv = (mem_resp != SCR1_MEM_RESP_NOTRDY) && (owner_q.size() > 0);
    if (popv) void'(owner_q.pop_front());
    if (acc) begin
      owner_q.push_back(s);
      last_grant = s;
      held_v     = 1'b0;
    end else if (mreq) begin
      held_v  = 1'b1;
      held_id = s;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_commit();
    #1;
  endtask

  task automatic set_idle();
    imem_req = 1'b0; dmem_req = 1'b0; mem_req_ack = 1'b0;
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    imem_cmd = SCR1_MEM_CMD_RD;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req = 1'b1; dmem_req = 1'b1; mem_req_ack = 1'b1; mem_resp = SCR1_MEM_RESP_RDY_OK;
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_mem_req got %b exp 0", mem_req);
    end
    vectors++;
    if ({imem_req_ack, dmem_req_ack} !== 2'b00) begin
      miscompares++; $display("FAIL reset_acks got %b%b exp 00", imem_req_ack, dmem_req_ack);
    end
    vectors++;
    if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
      miscompares++; $display("FAIL reset_resp got %0d/%0d exp 0/0", imem_resp, dmem_resp);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_single_imem();
    logic [VW-1:0] ev;
    imem_req = 1'b1; imem_addr = 32'h100; mem_req_ack = 1'b1;
    #2;
    vectors++;
    if ({mem_req, mem_addr, imem_req_ack} !== {1'b1, 32'h100, 1'b1}) begin
      miscompares++;
      $display("FAIL single_req got req=%b addr=%h ack=%b exp 1/100/1", mem_req, mem_addr, imem_req_ack);
    end
    vectors++; ev = model_expect();
    if (obs_vec() !== ev) begin miscompares++; $display("FAIL single_model0 got %h exp %h", obs_vec(), ev); end
    tick();
    imem_req = 1'b0; mem_req_ack = 1'b0;
    mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEADBEEF;
    #2;
    vectors++;
    if ({imem_resp, imem_rdata, dmem_resp} !== {SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, SCR1_MEM_RESP_NOTRDY}) begin
      miscompares++;
      $display("FAIL single_resp got %0d/%h/%0d exp 1/deadbeef/0", imem_resp, imem_rdata, dmem_resp);
    end
    vectors++; ev = model_expect();
    if (obs_vec() !== ev) begin miscompares++; $display("FAIL single_model1 got %h exp %h", obs_vec(), ev); end
    tick();
    set_idle();
  endtask

  task automatic test_round_robin();
    logic [VW-1:0] ev;
    bit exp_d;
    imem_req = 1'b1; imem_addr = 32'h1000;
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_HWORD;
    dmem_addr = 32'h3000; dmem_wdata = 32'h1234_5678; mem_req_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_resp  = (i == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
      mem_rdata = $urandom;
      #2;
      exp_d = (i % 2 == 0);
      vectors++;
      if ({imem_req_ack, dmem_req_ack} !== {!exp_d, exp_d}) begin
        miscompares++; $display("FAIL rr_grant[%0d] got %b%b exp %b%b", i, imem_req_ack, dmem_req_ack, !exp_d, exp_d);
      end
      if (i > 0) begin
        vectors++;
        if ((dmem_resp == SCR1_MEM_RESP_RDY_OK) !== !exp_d) begin
          miscompares++; $display("FAIL rr_route[%0d] got dresp=%0d iresp=%0d", i, dmem_resp, imem_resp);
        end
      end
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL rr_model[%0d] got %h exp %h", i, obs_vec(), ev); end
      tick();
    end
    imem_req = 1'b0; dmem_req = 1'b0; mem_req_ack = 1'b0;
    mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hCAFE_0001;
    #2;
    vectors++;
    if ({dmem_resp, dmem_rdata} !== {SCR1_MEM_RESP_RDY_OK, 32'hCAFE_0001}) begin
      miscompares++; $display("FAIL rr_last got %0d/%h exp 1/cafe0001", dmem_resp, dmem_rdata);
    end
    tick();
    set_idle();
  endtask

  task automatic test_lock_hold();
    logic [VW-1:0] ev;
    logic [1:0] exp_ack;
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr = 32'h2000; dmem_wdata = 32'hA5A5_0001; mem_req_ack = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2) begin imem_req = 1'b1; imem_addr = 32'h300; end
      if (c == 4) mem_req_ack = 1'b1;
      if (c == 5) dmem_req = 1'b0;
      #2;
      if (c <= 4) begin
        vectors++;
        if ({mem_req, mem_addr, mem_cmd} !== {1'b1, 32'h2000, SCR1_MEM_CMD_WR}) begin
          miscompares++; $display("FAIL lock_hold[%0d] got %b/%h/%0d exp 1/2000/1", c, mem_req, mem_addr, mem_cmd);
        end
      end
      exp_ack = (c <= 3) ? 2'b00 : (c == 4) ? 2'b01 : 2'b10;
      vectors++;
      if ({imem_req_ack, dmem_req_ack} !== exp_ack) begin
        miscompares++; $display("FAIL lock_ack[%0d] got %b%b exp %b", c, imem_req_ack, dmem_req_ack, exp_ack);
      end
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL lock_model[%0d] got %h exp %h", c, obs_vec(), ev); end
      tick();
    end
    set_idle();
    for (int k = 0; k < 4 && owner_q.size() > 0; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL lock_drain[%0d] got %h exp %h", k, obs_vec(), ev); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_full();
    logic [VW-1:0] ev;
    for (int c = 0; c <= 5; c++) begin
      case (c)
        0: begin imem_req = 1'b1; imem_addr = 32'h400; mem_req_ack = 1'b1; end
        1: begin imem_req = 1'b0; dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_addr = 32'h500; end
        2: begin imem_req = 1'b1; imem_addr = 32'h404; dmem_addr = 32'h504; end
        4: mem_resp = SCR1_MEM_RESP_RDY_ER;
        5: mem_resp = SCR1_MEM_RESP_NOTRDY;
        default: ;
      endcase
      #2;
      if (c >= 2 && c <= 4) begin
        vectors++;
        if ({mem_req, imem_req_ack, dmem_req_ack} !== 3'b000) begin
          miscompares++; $display("FAIL full_block[%0d] got %b%b%b exp 000", c, mem_req, imem_req_ack, dmem_req_ack);
        end
      end
      if (c == 4) begin
        vectors++;
        if ({imem_resp, dmem_resp} !== {SCR1_MEM_RESP_RDY_ER, SCR1_MEM_RESP_NOTRDY}) begin
          miscompares++; $display("FAIL full_err got %0d/%0d exp 2/0", imem_resp, dmem_resp);
        end
      end
      if (c == 5) begin
        vectors++;
        if ({mem_req, imem_req_ack} !== 2'b11) begin
          miscompares++; $display("FAIL full_resume got %b%b exp 11", mem_req, imem_req_ack);
        end
      end
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL full_model[%0d] got %h exp %h", c, obs_vec(), ev); end
      tick();
    end
    set_idle();
    for (int k = 0; k < 4 && owner_q.size() > 0; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL full_drain[%0d] got %h exp %h", k, obs_vec(), ev); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_push_pop();
    logic [VW-1:0] ev;
    for (int c = 0; c <= 4; c++) begin
      case (c)
        0: begin imem_req = 1'b1; imem_addr = 32'h600; mem_req_ack = 1'b1; end
        1: begin imem_req = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h700; mem_resp = SCR1_MEM_RESP_RDY_OK; end
        2: begin dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h604; end
        3: begin imem_req = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h704; mem_resp = SCR1_MEM_RESP_NOTRDY; end
        4: begin dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h608; end
        default: ;
      endcase
      #2;
      if (c == 1) begin
        vectors++;
        if ({imem_resp, dmem_resp, dmem_req_ack} !== {SCR1_MEM_RESP_RDY_OK, SCR1_MEM_RESP_NOTRDY, 1'b1}) begin
          miscompares++; $display("FAIL pp_older got %0d/%0d/%b exp 1/0/1", imem_resp, dmem_resp, dmem_req_ack);
        end
      end
      if (c == 2) begin
        vectors++;
        if ({imem_resp, dmem_resp, imem_req_ack} !== {SCR1_MEM_RESP_NOTRDY, SCR1_MEM_RESP_RDY_OK, 1'b1}) begin
          miscompares++; $display("FAIL pp_newer got %0d/%0d/%b exp 0/1/1", imem_resp, dmem_resp, imem_req_ack);
        end
      end
      if (c == 4) begin
        vectors++;
        if (mem_req !== 1'b0) begin
          miscompares++; $display("FAIL pp_count got mem_req=%b exp 0", mem_req);
        end
      end
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL pp_model[%0d] got %h exp %h", c, obs_vec(), ev); end
      tick();
    end
    set_idle();
    for (int k = 0; k < 4 && owner_q.size() > 0; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL pp_drain[%0d] got %h exp %h", k, obs_vec(), ev); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [VW-1:0] ev;
    for (int i = 0; i < 400; i++) begin
      if (!imem_req && $urandom_range(0, 1) != 0) begin
        imem_req = 1'b1; imem_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dmem_req && $urandom_range(0, 1) != 0) begin
        dmem_req   = 1'b1;
        dmem_cmd   = ($urandom_range(0, 1) != 0) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        case ($urandom_range(0, 2))
          0:       dmem_width = SCR1_MEM_WIDTH_BYTE;
          1:       dmem_width = SCR1_MEM_WIDTH_HWORD;
          default: dmem_width = SCR1_MEM_WIDTH_WORD;
        endcase
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
      end
      mem_req_ack = ($urandom_range(0, 2) != 0);
      if (owner_q.size() > 0 && $urandom_range(0, 1) != 0)
        mem_resp = ($urandom_range(0, 3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      else
        mem_resp = SCR1_MEM_RESP_NOTRDY;
      mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL rand[%0d] got %h exp %h", i, obs_vec(), ev); end
      tick();
      if (ev[B_IACK]) imem_req = 1'b0;
      if (ev[B_DACK]) dmem_req = 1'b0;
    end
    set_idle();
    for (int k = 0; k < 4 && owner_q.size() > 0; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL rand_drain[%0d] got %h exp %h", k, obs_vec(), ev); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] ev;
    imem_req = 1'b1; imem_addr = 32'h800; mem_req_ack = 1'b1;
    tick();
    imem_req = 1'b0; dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_addr = 32'h900;
    tick();
    imem_req = 1'b1; imem_addr = 32'h804; dmem_addr = 32'h904; mem_resp = SCR1_MEM_RESP_RDY_OK;
    #2;
    vectors++; ev = model_expect();
    if (obs_vec() !== ev) begin miscompares++; $display("FAIL rstmid_pre got %h exp %h", obs_vec(), ev); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, imem_req_ack, dmem_req_ack, imem_resp, dmem_resp} !== 7'b0) begin
      miscompares++;
      $display("FAIL rstmid_out got %b%b%b %0d/%0d exp 000 0/0", mem_req, imem_req_ack, dmem_req_ack, imem_resp, dmem_resp);
    end
    model_reset();
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({dmem_req_ack, imem_req_ack, mem_addr} !== {1'b1, 1'b0, 32'h904}) begin
      miscompares++; $display("FAIL rstmid_tie got d=%b i=%b addr=%h exp 1/0/904", dmem_req_ack, imem_req_ack, mem_addr);
    end
    vectors++; ev = model_expect();
    if (obs_vec() !== ev) begin miscompares++; $display("FAIL rstmid_post got %h exp %h", obs_vec(), ev); end
    tick();
    set_idle();
    for (int k = 0; k < 4 && owner_q.size() > 0; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = $urandom;
      #2;
      vectors++; ev = model_expect();
      if (obs_vec() !== ev) begin miscompares++; $display("FAIL rstmid_drain[%0d] got %h exp %h", k, obs_vec(), ev); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    set_idle();
    test_reset();
    test_single_imem();
    test_round_robin();
    test_lock_hold();
    test_full();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
